// File: rtl/iigs_pkg.sv
// Shared IIgs shadowing definitions: $C035 bit positions, video region bounds,
// the shadow write queue entry layout and the drain FSM states.
package iigs_pkg;

  localparam int SHD_TXT1 = 0;
  localparam int SHD_HGR1 = 1;
  localparam int SHD_HGR2 = 2;
  localparam int SHD_SHR  = 3;
  localparam int SHD_AUX  = 4;
  localparam int SHD_TXT2 = 5;
  localparam int SHD_IOLC = 6;

  localparam logic [7:0] BANK_FAST0 = 8'h00;
  localparam logic [7:0] BANK_FAST1 = 8'h01;

  localparam logic [15:0] TXT1_LO = 16'h0400;
  localparam logic [15:0] TXT1_HI = 16'h07FF;
  localparam logic [15:0] TXT2_LO = 16'h0800;
  localparam logic [15:0] TXT2_HI = 16'h0BFF;
  localparam logic [15:0] HGR1_LO = 16'h2000;
  localparam logic [15:0] HGR1_HI = 16'h3FFF;
  localparam logic [15:0] HGR2_LO = 16'h4000;
  localparam logic [15:0] HGR2_HI = 16'h5FFF;
  localparam logic [15:0] SHR_LO  = 16'h2000;
  localparam logic [15:0] SHR_HI  = 16'h9FFF;

  typedef struct packed {
    logic        bank1;
    logic [15:0] addr;
    logic [7:0]  data;
  } wq_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_e;

  function automatic logic in_range(input logic [15:0] a,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/shadow_wq_if.sv
// Slow-side Mega II RAM write port: the queue is master, the arbiter is slave.
interface shadow_wq_if;
  logic        s_req;
  logic        s_bank1;
  logic [15:0] s_addr;
  logic [7:0]  s_data;
  logic        s_ack;

  modport master (output s_req, s_bank1, s_addr, s_data, input s_ack);
  modport slave  (input s_req, s_bank1, s_addr, s_data, output s_ack);
endinterface

// File: rtl/shadow_decode.sv
// Combinational shadow region filter: decides whether a fast-bank CPU write
// must be mirrored into slow RAM given the current $C035 value.
module shadow_decode
  import iigs_pkg::*;
(
  input  logic [7:0]  bank_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  shadow_i,
  output logic        hit_o
);

  logic fast_bank;
  logic is_bank1;
  logic aux_ok;
  logic txt1_hit;
  logic txt2_hit;
  logic hgr1_hit;
  logic hgr2_hit;
  logic shr_hit;
  logic unused_shadow;

  assign unused_shadow = ^shadow_i[7:6];

  always_comb begin
    fast_bank = (bank_i == BANK_FAST0) || (bank_i == BANK_FAST1);
    is_bank1  = (bank_i == BANK_FAST1);
    // Hires pages in the aux bank are additionally gated by the aux inhibit bit
    aux_ok    = !is_bank1 || !shadow_i[SHD_AUX];
    txt1_hit  = in_range(addr_i, TXT1_LO, TXT1_HI) && !shadow_i[SHD_TXT1];
    txt2_hit  = in_range(addr_i, TXT2_LO, TXT2_HI) && !shadow_i[SHD_TXT2];
    hgr1_hit  = in_range(addr_i, HGR1_LO, HGR1_HI) && !shadow_i[SHD_HGR1] && aux_ok;
    hgr2_hit  = in_range(addr_i, HGR2_LO, HGR2_HI) && !shadow_i[SHD_HGR2] && aux_ok;
    shr_hit   = is_bank1 && in_range(addr_i, SHR_LO, SHR_HI) && !shadow_i[SHD_SHR];
    hit_o     = fast_bank && (txt1_hit || txt2_hit || hgr1_hit || hgr2_hit || shr_hit);
  end

endmodule

// File: rtl/shadow_wq.sv
// Shadow write queue: buffers shadowed fast-RAM writes and replays them to
// slow RAM $E0/$E1 at the 1 MHz rate. SHADOW_COALESCE_EN merges same-address tail writes.
module shadow_wq
  import iigs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_bank,
  input  logic [15:0]            wr_addr,
  input  logic [7:0]             wr_data,
  input  logic [7:0]             shadow,
  input  logic                   slow_cen,
  shadow_wq_if.master            slow,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wq_entry_t    mem [DEPTH];
  wq_entry_t    new_entry;
  wq_entry_t    issue_entry;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] tail_idx;
  logic [PW-1:0] mem_wr_idx;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q;
  logic          overflow_q, overflow_d;

  drain_state_e  state_q;
  logic          s_req_q;
  logic          s_bank1_q;
  logic [15:0]   s_addr_q;
  logic [7:0]    s_data_q;

  logic hit;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic coalesce;

  shadow_decode u_decode (
    .bank_i   (wr_bank),
    .addr_i   (wr_addr),
    .shadow_i (shadow),
    .hit_o    (hit)
  );

  assign new_entry = '{bank1: wr_bank[0], addr: wr_addr, data: wr_data};
  assign full      = (count_q == FULL_CNT);
  assign pop       = (state_q == ST_REQ) && slow.s_ack;
  assign tail_idx  = wr_ptr_q - PW'(1);

`ifdef SHADOW_COALESCE_EN
  logic [16:0] tail_key_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail_key_q <= '0;
    end else if (push) begin
      tail_key_q <= {wr_bank[0], wr_addr};
    end
  end

  // The head is frozen once it is being offered to slow RAM
  assign coalesce = wr_en && hit && (count_q != '0) &&
                    (tail_key_q == {wr_bank[0], wr_addr}) &&
                    !((count_q == CW'(1)) && (state_q == ST_REQ));
`else
  assign coalesce = 1'b0;
`endif

  assign push = wr_en && hit && !coalesce && (!full || pop);
  assign drop = wr_en && hit && !coalesce && full && !pop;

  assign mem_wr_idx = coalesce ? tail_idx : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (push || coalesce) begin
      mem[mem_wr_idx] <= new_entry;
    end
  end

  // Forward a coalesced write that lands on the head in the very cycle it issues
  always_comb begin
    issue_entry = mem[rd_ptr_q];
    if (coalesce && (count_q == CW'(1))) begin
      issue_entry = new_entry;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= (count_d == FULL_CNT);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      s_req_q   <= 1'b0;
      s_bank1_q <= 1'b0;
      s_addr_q  <= '0;
      s_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (slow_cen && (count_q != '0)) begin
            state_q   <= ST_REQ;
            s_req_q   <= 1'b1;
            s_bank1_q <= issue_entry.bank1;
            s_addr_q  <= issue_entry.addr;
            s_data_q  <= issue_entry.data;
          end
        end
        ST_REQ: begin
          if (slow.s_ack) begin
            state_q <= ST_IDLE;
            s_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign slow.s_req   = s_req_q;
  assign slow.s_bank1 = s_bank1_q;
  assign slow.s_addr  = s_addr_q;
  assign slow.s_data  = s_data_q;
  assign stall        = stall_q;
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_shadow_wq.sv
// Directed bench for shadow_wq: scoreboard of expected slow-RAM writes,
// compared when the queue raises s_req.
module tb_shadow_wq;
  import iigs_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_bank = '0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  shadow = '0;
  logic        slow_cen = 1'b0;
  logic        stall;
  logic [3:0]  count;
  logic        overflow;

  shadow_wq_if wq_if ();

  shadow_wq #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .shadow   (shadow),
    .slow_cen (slow_cen),
    .slow     (wq_if),
    .stall    (stall),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  sh;
    bit          q;
  } vec_t;

  wq_entry_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs [13] = '{
    '{8'h00, 16'h0400, 8'h50, 8'h01, 1'b0},
    '{8'h01, 16'h2000, 8'h55, 8'h16, 1'b1},
    '{8'h01, 16'h2000, 8'h56, 8'h00, 1'b1},
    '{8'h02, 16'h0400, 8'h57, 8'h00, 1'b0},
    '{8'h00, 16'h0800, 8'h58, 8'h20, 1'b0},
    '{8'h00, 16'h0BFF, 8'h59, 8'h00, 1'b1},
    '{8'h00, 16'h0C00, 8'h5A, 8'h00, 1'b0},
    '{8'h00, 16'h4000, 8'h5B, 8'h10, 1'b1},
    '{8'h01, 16'h4000, 8'h5C, 8'h1C, 1'b0},
    '{8'h01, 16'h9FFF, 8'h5D, 8'h00, 1'b1},
    '{8'h01, 16'hA000, 8'h5E, 8'h00, 1'b0},
    '{8'h00, 16'h03FF, 8'h5F, 8'h00, 1'b0},
    '{8'h00, 16'h5FFF, 8'h60, 8'h04, 1'b0}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] sh, input bit expect_q);
    wr_en   = 1'b1;
    wr_bank = b;
    wr_addr = a;
    wr_data = d;
    shadow  = sh;
    if (expect_q) sb.push_back('{bank1: b[0], addr: a, data: d});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic compare_head(input string tag);
    wq_entry_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb observed=s_req expected=no_request", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_bank1"}, 32'(wq_if.s_bank1), 32'(e.bank1));
      check({tag, "_addr"},  32'(wq_if.s_addr),  32'(e.addr));
      check({tag, "_data"},  32'(wq_if.s_data),  32'(e.data));
    end
  endtask

  task automatic drain_one(input string tag);
    logic [15:0] a_seen;
    slow_cen = 1'b1;
    tick();
    slow_cen = 1'b0;
    check({tag, "_req"}, 32'(wq_if.s_req), 32'd1);
    a_seen = wq_if.s_addr;
    compare_head(tag);
    tick();
    check({tag, "_hold_req"},  32'(wq_if.s_req),  32'd1);
    check({tag, "_hold_addr"}, 32'(wq_if.s_addr), 32'(a_seen));
    wq_if.s_ack = 1'b1;
    tick();
    wq_if.s_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(wq_if.s_req), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_exp;
    wq_if.s_ack = 1'b0;
    tick();
    tick();
    check("rst_s_req",    32'(wq_if.s_req),   32'd0);
    check("rst_s_bank1",  32'(wq_if.s_bank1), 32'd0);
    check("rst_s_addr",   32'(wq_if.s_addr),  32'd0);
    check("rst_s_data",   32'(wq_if.s_data),  32'd0);
    check("rst_stall",    32'(stall),         32'd0);
    check("rst_count",    32'(count),         32'd0);
    check("rst_overflow", 32'(overflow),      32'd0);
    reset_n = 1'b1;
    tick();

    // Enqueue into empty queue with slow_cen in the same cycle: no issue yet
    slow_cen = 1'b1;
    cpu_write(8'h00, 16'h0400, 8'hC1, 8'h08, 1'b1);
    slow_cen = 1'b0;
    check("same_cycle_no_req", 32'(wq_if.s_req), 32'd0);
    check("txt1_count", 32'(count), 32'd1);
    drain_one("txt1");
    check("txt1_empty", 32'(count), 32'd0);

    // Acknowledge while idle must not pop
    cpu_write(8'h00, 16'h0401, 8'hC2, 8'h08, 1'b1);
    wq_if.s_ack = 1'b1;
    tick();
    wq_if.s_ack = 1'b0;
    check("idle_ack_count", 32'(count), 32'd1);
    check("idle_ack_req",   32'(wq_if.s_req), 32'd0);
    drain_one("idle_ack");

    // Region decode table
    n_exp = 0;
    foreach (vecs[i]) begin
      cpu_write(vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].sh, vecs[i].q);
      if (vecs[i].q) n_exp++;
    end
    check("decode_count", 32'(count), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) drain_one("decode");
    check("decode_empty", 32'(count), 32'd0);

    // Fill to full, ninth write dropped
    for (int i = 0; i < 9; i++) begin
      cpu_write(8'h00, 16'h0400 + 16'(i), 8'h80 + 8'(i), 8'h00, i < 8);
      if (i == 6) check("fill7_stall", 32'(stall), 32'd0);
      if (i == 7) begin
        check("fill8_stall", 32'(stall), 32'd1);
        check("fill8_count", 32'(count), 32'd8);
        check("fill8_ovf",   32'(overflow), 32'd0);
      end
    end
    check("drop_count", 32'(count), 32'd8);
    check("drop_ovf",   32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) drain_one("fifo");
    check("fifo_empty", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("fifo_stall", 32'(stall), 32'd0);

    // Full queue, write coincident with the pop
    do_reset();
    check("reset_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cpu_write(8'h00, 16'h0600 + 16'(i), 8'h30 + 8'(i), 8'h00, 1'b1);
    slow_cen = 1'b1;
    tick();
    slow_cen = 1'b0;
    check("fullpop_req", 32'(wq_if.s_req), 32'd1);
    compare_head("fullpop_head");
    wq_if.s_ack = 1'b1;
    cpu_write(8'h01, 16'h0610, 8'hAA, 8'h00, 1'b1);
    wq_if.s_ack = 1'b0;
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_ovf",   32'(overflow), 32'd0);
    check("fullpop_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 8; i++) drain_one("fullpop");
    check("fullpop_empty", 32'(count), 32'd0);

    // Same-address writes back to back
    cpu_write(8'h00, 16'h0500, 8'h11, 8'h00, 1'b0);
`ifdef SHADOW_COALESCE_EN
    cpu_write(8'h00, 16'h0500, 8'h22, 8'h00, 1'b0);
    sb.push_back('{bank1: 1'b0, addr: 16'h0500, data: 8'h22});
    check("coal_count", 32'(count), 32'd1);
`else
    sb.push_back('{bank1: 1'b0, addr: 16'h0500, data: 8'h11});
    cpu_write(8'h00, 16'h0500, 8'h22, 8'h00, 1'b1);
    check("coal_count", 32'(count), 32'd2);
`endif
    n_exp = sb.size();
    for (int i = 0; i < n_exp; i++) drain_one("coal");
    check("coal_empty", 32'(count), 32'd0);

    // Reset during an outstanding request
    cpu_write(8'h00, 16'h0700, 8'h77, 8'h00, 1'b1);
    cpu_write(8'h00, 16'h0701, 8'h78, 8'h00, 1'b1);
    slow_cen = 1'b1;
    tick();
    slow_cen = 1'b0;
    check("mid_req_up", 32'(wq_if.s_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_req_async_req",   32'(wq_if.s_req), 32'd0);
    check("mid_req_async_count", 32'(count), 32'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    slow_cen = 1'b1;
    tick();
    tick();
    tick();
    slow_cen = 1'b0;
    check("post_rst_req",   32'(wq_if.s_req), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
